// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared tetromino types and constants
package tetris_pkg;

  typedef enum logic [2:0] {
    SHAPE_I = 3'd0,
    SHAPE_O = 3'd1,
    SHAPE_T = 3'd2,
    SHAPE_S = 3'd3,
    SHAPE_Z = 3'd4,
    SHAPE_J = 3'd5,
    SHAPE_L = 3'd6
  } shape_t;

  localparam int         NUM_SHAPES = 7;
  localparam logic [6:0] BAG_FULL   = 7'b1111111;
  localparam logic [6:0] BAG_RESET  = 7'b0000001;

  // The random source can produce 7, which is not a shape; fold it onto I.
  function automatic shape_t to_cand(input logic [2:0] rnd);
    return (rnd == 3'd7) ? SHAPE_I : shape_t'(rnd);
  endfunction

  function automatic shape_t wrap7(input logic [3:0] v);
    return shape_t'((v >= 4'd7) ? 3'(v - 4'd7) : v[2:0]);
  endfunction

endpackage

// File: rtl/nextblock_if.sv
// rtl/nextblock_if.sv - request/random/shape bundle between game logic and nextblock
interface nextblock_if;
  import tetris_pkg::*;

  logic       next;
  logic [2:0] random;
  shape_t     shape;

  modport master (output next, output random, input shape);
  modport slave  (input next, input random, output shape);
endinterface

// File: rtl/nextblock_bag_picker.sv
// rtl/nextblock_bag_picker.sv - combinational 7-bag scan from the candidate shape
module bag_picker
  import tetris_pkg::*;
(
  input  shape_t     i_cand,
  input  logic [6:0] i_bag_used,
  output shape_t     o_shape,
  output logic [6:0] o_bag_used
);

  logic [6:0] w_mask;

  // First unused shape at or after the candidate, wrapping modulo 7.
  always_comb begin
    logic   w_found;
    shape_t w_idx;
    w_found = 1'b0;
    w_idx   = i_cand;
    o_shape = i_cand;
    for (int i = 0; i < NUM_SHAPES; i++) begin
      w_idx = wrap7({1'b0, i_cand} + 4'(i));
      if (!w_found && !i_bag_used[w_idx]) begin
        o_shape = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_mask     = i_bag_used | (7'd1 << o_shape);
    o_bag_used = (w_mask == BAG_FULL) ? 7'd0 : w_mask;
  end

endmodule

// File: rtl/nextblock.sv
// rtl/nextblock.sv - next-piece register with request edge detect and optional 7-bag
module nextblock
  import tetris_pkg::*;
#(
  parameter bit BAG_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  nextblock_if.slave  i_bus
);

  shape_t     r_shape;
  logic [6:0] r_bag_used;
  logic       r_next_q;

  logic       w_req;
  shape_t     w_cand;
  shape_t     w_pick;
  logic [6:0] w_pick_mask;

  always_comb begin
    w_req  = i_bus.next & ~r_next_q;
    w_cand = to_cand(i_bus.random);
  end

  bag_picker u_picker (
    .i_cand     (w_cand),
    .i_bag_used (r_bag_used),
    .o_shape    (w_pick),
    .o_bag_used (w_pick_mask)
  );

  // Plain-random mode never tracks a bag, so its mask stays zero from reset on.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shape    <= SHAPE_I;
      r_bag_used <= BAG_EN ? BAG_RESET : 7'd0;
      r_next_q   <= 1'b0;
    end else begin
      r_next_q <= i_bus.next;
      if (w_req) begin
        if (BAG_EN) begin
          r_shape    <= w_pick;
          r_bag_used <= w_pick_mask;
        end else begin
          r_shape    <= w_cand;
          r_bag_used <= 7'd0;
        end
      end
    end
  end

  assign i_bus.shape = r_shape;

endmodule

// File: tb/tb_nextblock.sv
// tb/tb_nextblock.sv - directed vector bench for bag and plain nextblock variants
module tb_nextblock;
  import tetris_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nextblock_if bag_if ();
  nextblock_if raw_if ();

  nextblock #(.BAG_EN(1'b1)) u_bag (.i_clk(clk), .i_rst(rst), .i_bus(bag_if.slave));
  nextblock #(.BAG_EN(1'b0)) u_raw (.i_clk(clk), .i_rst(rst), .i_bus(raw_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       nxt;
    logic [2:0] rnd;
    logic [2:0] exp_bag;
    logic [2:0] exp_raw;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic n, input logic [2:0] r);
    bag_if.next   = n;
    bag_if.random = r;
    raw_if.next   = n;
    raw_if.random = r;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic request(input logic [2:0] r, input logic [2:0] eb, input logic [2:0] er, input string name);
    drive(1'b1, r);
    cycle();
    check({name, "_bag"}, {4'd0, bag_if.shape}, {4'd0, eb});
    check({name, "_raw"}, {4'd0, raw_if.shape}, {4'd0, er});
    drive(1'b0, r);
    cycle();
  endtask

  task automatic add(input logic n, input logic [2:0] r, input logic [2:0] eb, input logic [2:0] er);
    vec_t v;
    v.nxt = n; v.rnd = r; v.exp_bag = eb; v.exp_raw = er;
    vecs.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 3'd0);

    // Idle, rising edge, held level, random=7 fold, wrap past used shapes, full-bag clear.
    for (int i = 0; i < 3; i++) add(1'b0, 3'd2, 3'd0, 3'd0);
    add(1'b1, 3'd3, 3'd3, 3'd3);
    for (int i = 0; i < 4; i++) add(1'b1, 3'd5, 3'd3, 3'd3);
    add(1'b0, 3'd5, 3'd3, 3'd3);
    add(1'b1, 3'd7, 3'd1, 3'd0);
    add(1'b0, 3'd0, 3'd1, 3'd0);
    add(1'b1, 3'd6, 3'd6, 3'd6);
    add(1'b0, 3'd1, 3'd6, 3'd6);
    add(1'b1, 3'd5, 3'd5, 3'd5);
    add(1'b0, 3'd0, 3'd5, 3'd5);
    add(1'b1, 3'd4, 3'd4, 3'd4);
    add(1'b0, 3'd0, 3'd4, 3'd4);
    add(1'b1, 3'd6, 3'd2, 3'd6);
    add(1'b0, 3'd0, 3'd2, 3'd6);
    add(1'b1, 3'd2, 3'd2, 3'd2);

    do_reset();
    check("reset_shape_bag", {4'd0, bag_if.shape}, 7'd0);
    check("reset_shape_raw", {4'd0, raw_if.shape}, 7'd0);
    check("reset_mask", u_bag.r_bag_used, 7'b0000001);

    foreach (vecs[i]) begin
      drive(vecs[i].nxt, vecs[i].rnd);
      cycle();
      check($sformatf("vec%0d_bag", i), {4'd0, bag_if.shape}, {4'd0, vecs[i].exp_bag});
      check($sformatf("vec%0d_raw", i), {4'd0, raw_if.shape}, {4'd0, vecs[i].exp_raw});
    end
    check("mask_after_clear_draw", u_bag.r_bag_used, 7'b0000100);

    // Six draws with random=0 exhaust the bag, then a fresh bag honours the candidate.
    do_reset();
    for (int k = 1; k <= 6; k++)
      request(3'd0, 3'(k), 3'd0, $sformatf("bag_fill%0d", k));
    check("bag_cleared", u_bag.r_bag_used, 7'd0);
    request(3'd4, 3'd4, 3'd4, "bag_new");

    // Reset wins over a request in the same cycle and discards bag history.
    rst = 1'b1;
    drive(1'b1, 3'd5);
    cycle();
    check("rst_req_shape", {4'd0, bag_if.shape}, 7'd0);
    check("rst_req_mask", u_bag.r_bag_used, 7'b0000001);
    rst = 1'b0;
    drive(1'b0, 3'd5);
    cycle();
    check("rst_req_hold", {4'd0, bag_if.shape}, 7'd0);
    request(3'd0, 3'd1, 3'd0, "post_rst");

    // Plain mode: repeated candidate is not filtered.
    request(3'd3, 3'd3, 3'd3, "raw_a");
    request(3'd3, 3'd4, 3'd3, "raw_b");
    request(3'd7, 3'd2, 3'd0, "raw_c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nextblock.md
# nextblock

Next-piece selector for the Tetris game core. It holds the tetromino shown in the "next" preview and draws a fresh one each time the game logic requests a new piece. The draw uses an external 3-bit random source, filtered through a 7-bag so every shape appears once per seven draws. It sits between the LFSR random generator and the piece-spawn / preview-render logic.

## Interface
- BAG_EN, default 1: 1 = 7-bag selection; 0 = plain random with 7 remapped to 0.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- next  input  1  level request from game logic; only a 0→1 transition consumes a piece.
- random  input  3  free-running random value, sampled on the request edge.
- shape  output  3  registered next-piece code: 0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L. Never 7.

## Operation
- State:
  - shape register (3 b).
  - bag_used mask (7 b, bit k = shape k already dealt this bag).
  - next_q (previous sampled `next`).
- Request detect: `req = next & ~next_q`. `next_q <= next` every cycle.
- Candidate: `cand = (random == 7) ? 0 : random`.
- BAG_EN=1:
  - Scan `cand, cand+1, … ` modulo 7.
  - Select the first shape whose bag_used bit is 0.
  - Load it into shape and set its bag bit.
  - If the resulting mask is 7'b1111111, clear the mask to 0 in the same cycle, so a new bag starts.
- BAG_EN=0: load `cand` directly; bag_used stays 0.
- No request: shape and bag_used hold.
- Reset:
  - shape = 0.
  - bag_used = 7'b0000001 (the reset piece I counts as dealt).
  - next_q = 0.
- Reset has priority over a simultaneous request.
- Reset mid-bag discards the bag history.

## Timing
- Request sampled on edge N (next=1, next_q=0); new shape visible after edge N. Latency: 1 clock.
- `next` held high for many cycles yields exactly one draw. It must return low for ≥1 cycle before the next draw.
- `random` is only sampled on the request edge. Changes at any other time have no effect.
- Combinational scan completes within one cycle. With a valid mask (not all ones) an unused shape always exists.
- No output other than shape. shape is glitch-free (registered).

## Structure
- Shared package `tetris_pkg`:
  - `shape_t` 3-bit enum (I,O,T,S,Z,J,L).
  - `NUM_SHAPES = 7`.
  - Shape constants used by spawn/render logic.
- One natural sub-module: `bag_picker`. It is combinational: inputs `cand` and `bag_used`; outputs the selected shape and the updated mask, including the full-bag clear.
- Top level holds the registers, edge detect, reset and the BAG_EN mux.

## Test plan
- Reset, then next=0 with random=2 for 3 cycles → shape stays 0, no change.
- Rising next with random=3 → shape=3 one clock later. Hold next=1 with random=5 for 4 cycles → shape stays 3.
- After the above, drop next, then a request with random=7 → candidate 0 is used, scan → shape=1.
- From reset, requests with random=0 six times → shapes 1,2,3,4,5,6. Bag then clears. Seventh request with random=4 → shape=4.
- Request asserted in the same cycle as rst=1 → shape=0, bag_used=0000001. Next request with random=0 → shape=1.
- BAG_EN=0: requests with random=3, 3, 7 → shape=3, 3, 0.
